// File: rtl/fp_operand_unpack_pkg.sv
// Shared configuration for the FP add/sub front end: default field widths,
// operand class codes and the skid-buffer occupancy states.
`ifndef EXP_SIZE
`define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
`define MANTIS_SIZE 23
`endif

package fp_operand_unpack_pkg;

  localparam logic [2:0] ZERO      = 3'b000;
  localparam logic [2:0] INF       = 3'b001;
  localparam logic [2:0] SUBNORMAL = 3'b010;
  localparam logic [2:0] NORMAL    = 3'b011;
  localparam logic [2:0] NAN       = 3'b100;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: maps {exp, mantis} to a class code.
// The sign bit is deliberately not an input.
module fp_classify
  import fp_operand_unpack_pkg::*;
#(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE
) (
  input  logic [EXP_SIZE-1:0]    exp_i,
  input  logic [MANTIS_SIZE-1:0] mantis_i,
  output logic [2:0]             class_o
);

  always_comb begin
    class_o = NORMAL;
    if (&exp_i) begin
      class_o = (|mantis_i) ? NAN : INF;
    end else if (~|exp_i) begin
      class_o = (|mantis_i) ? SUBNORMAL : ZERO;
    end
  end

endmodule

// File: rtl/fp_operand_unpack.sv
// Operand unpack stage: splits and classifies both operands, then registers
// them behind a valid/ready skid buffer (main register + one skid register).
module fp_operand_unpack
  import fp_operand_unpack_pkg::*;
#(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            op_sub,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]   operand_A,
  input  logic [EXP_SIZE+MANTIS_SIZE:0]   operand_B,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sign_A,
  output logic                            sign_B,
  output logic [EXP_SIZE-1:0]             exp_A,
  output logic [EXP_SIZE-1:0]             exp_B,
  output logic [MANTIS_SIZE-1:0]          mantis_A,
  output logic [MANTIS_SIZE-1:0]          mantis_B,
  output logic [2:0]                      type_A,
  output logic [2:0]                      type_B
);

  localparam int OPW = 1 + EXP_SIZE + MANTIS_SIZE;
  localparam int PW  = 2 * (EXP_SIZE + MANTIS_SIZE) + 8;

  // Handshake: a pair moves in on in_valid & in_ready and out on
  // out_valid & out_ready; in_ready comes straight from state_q.
  logic [EXP_SIZE-1:0]    a_exp, b_exp;
  logic [MANTIS_SIZE-1:0] a_man, b_man;
  logic [2:0]             a_cls, b_cls;
  logic [PW-1:0]          pair_in;
  logic [PW-1:0]          main_q, main_d, skid_q, skid_d;
  skid_state_e            state_q, state_d;
  logic                   in_xfer, out_xfer;

  assign a_exp = operand_A[OPW-2 -: EXP_SIZE];
  assign b_exp = operand_B[OPW-2 -: EXP_SIZE];
  assign a_man = operand_A[MANTIS_SIZE-1:0];
  assign b_man = operand_B[MANTIS_SIZE-1:0];

  fp_classify #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_class_a (
    .exp_i(a_exp), .mantis_i(a_man), .class_o(a_cls)
  );
  fp_classify #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_class_b (
    .exp_i(b_exp), .mantis_i(b_man), .class_o(b_cls)
  );

  // Subtraction is folded into B's sign; its class is left untouched.
  assign pair_in = {operand_A[OPW-1], operand_B[OPW-1] ^ op_sub,
                    a_exp, b_exp, a_man, b_man, a_cls, b_cls};

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  assign {sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B, type_A, type_B} = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = pair_in;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = pair_in;
        end else if (in_xfer) begin
          skid_d  = pair_in;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Zeroed payload decodes as both classes ZERO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
